// File: rtl/udp_pkg.sv
// Shared UDP TX-side definitions: scheduler state encoding and payload byte-count width.
package udp_pkg;

  localparam int UDP_BYTE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } udp_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at MAX and returns to zero whenever clr is high.
module sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != W'(MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/udp_fifo_rd_sched.sv
// Read-side packet scheduler: decides when the capture FIFO holds a packet worth sending,
// starts the UDP transmission and streams exactly that many words on the core's requests.
module udp_fifo_rd_sched
  import udp_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LVL_W     = 10,
  parameter int PKT_WORDS = 256,
  parameter int TIMEOUT   = 50000,
  parameter int GAP_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [LVL_W-1:0]      fifo_rd_level,
  input  logic                  fifo_empty,
  input  logic [DATA_W-1:0]     fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx_start_en,
  output logic [UDP_BYTE_W-1:0] tx_byte_num,
  input  logic                  tx_req,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic [15:0]           pkt_cnt,
  output logic                  err
);

  localparam int TMR_W = $clog2(TIMEOUT + 2);
  localparam int GAP_W = $clog2(GAP_CYC + 2);
  localparam logic [LVL_W-1:0] PKT_LVL = LVL_W'(PKT_WORDS);

  udp_state_t       state, state_nxt;
  logic [LVL_W-1:0] rem;
  logic [LVL_W-1:0] n_words;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic             lvl_full, lvl_part, launch, req_err;

  assign lvl_full = fifo_rd_level >= PKT_LVL;
  assign lvl_part = (fifo_rd_level != '0) && !lvl_full;
  assign launch   = enable && (lvl_full || ((fifo_rd_level != '0) && (timer == TMR_W'(TIMEOUT))));
  assign n_words  = lvl_full ? PKT_LVL : fifo_rd_level;
  assign tx_data  = fifo_rd_data;

  // A request with nothing left to send, or one the FIFO cannot serve, is a protocol fault.
  assign req_err = tx_req && (((state == ST_SEND) && fifo_empty) ||
                              (state == ST_WAIT_DONE) || (state == ST_GAP));

  sat_counter #(.W(TMR_W), .MAX(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!((state == ST_IDLE) && lvl_part)),
    .cnt   (timer)
  );

  sat_counter #(.W(GAP_W), .MAX(GAP_CYC)) u_gap (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_GAP),
    .cnt   (gap_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // GAP_CYC must be at least 1; GAP lasts exactly GAP_CYC cycles.
  always_comb begin
    state_nxt   = state;
    fifo_rd_en  = 1'b0;
    tx_start_en = 1'b0;
    busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (launch) state_nxt = ST_START;
      end
      ST_START: begin
        tx_start_en = 1'b1;
        state_nxt   = ST_SEND;
      end
      ST_SEND: begin
        if (tx_req && (rem != '0) && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          if (rem == LVL_W'(1)) state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYC - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      tx_byte_num <= '0;
      pkt_cnt     <= '0;
      err         <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && launch) begin
        rem         <= n_words;
        tx_byte_num <= UDP_BYTE_W'({n_words, 1'b0});
      end else if (fifo_rd_en) begin
        rem <= rem - LVL_W'(1);
      end
      if (state == ST_START) pkt_cnt <= pkt_cnt + 16'd1;
      if (req_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_fifo_rd_sched.sv
// Bench for udp_fifo_rd_sched: queue-backed FIFO, randomized UDP requests and a per-cycle
// behavioural model of the packet schedule.
module tb_udp_fifo_rd_sched;

  localparam int DATA_W    = 16;
  localparam int LVL_W     = 10;
  localparam int PKT_WORDS = 256;
  localparam int TIMEOUT   = 100;
  localparam int GAP_CYC   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [LVL_W-1:0]  fifo_rd_level = '0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_rd_data = '0;
  logic              fifo_rd_en;
  logic              tx_start_en;
  logic [15:0]       tx_byte_num;
  logic              tx_req = 1'b0;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done = 1'b0;
  logic              busy;
  logic [15:0]       pkt_cnt;
  logic              err;

  always #5 clk = ~clk;

  udp_fifo_rd_sched #(
    .DATA_W(DATA_W), .LVL_W(LVL_W), .PKT_WORDS(PKT_WORDS), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_rd_level(fifo_rd_level),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .pkt_cnt(pkt_cnt), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO environment
  logic [DATA_W-1:0] q[$];
  int wr_seq = 0;
  bit starve = 0;

  function automatic void refresh();
    fifo_rd_level = LVL_W'((q.size() > 1023) ? 1023 : q.size());
    fifo_empty    = (q.size() == 0) || starve;
  endfunction

  task automatic push(input int k);
    for (int i = 0; i < k; i++) begin
      q.push_back(DATA_W'(wr_seq));
      wr_seq++;
    end
    refresh();
  endtask

  int cyc = 0;
  int s_cyc = 0;
  int n_starts = 0;
  bit s_start, s_rd;

  task automatic tick();
    @(negedge clk);
    s_start = tx_start_en;
    s_rd    = fifo_rd_en;
    s_cyc   = cyc;
    if (s_start) n_starts++;
    @(posedge clk);
    cyc++;
    #1;
    if (s_rd && q.size() > 0) fifo_rd_data = q.pop_front();
    refresh();
  endtask

  // Behavioural model: packet bookkeeping in words/cycles, checked every cycle.
  bit m_start = 0, m_await = 0, m_err = 0, data_due = 0;
  int m_words = 0, m_gap = 0, m_idle = 0, m_pkts = 0, m_bytes = 0, m_reads = 0;

  task automatic model_cycle();
    bit idle, exp_rd, launch;
    int n, lvl;
    if (data_due) chk("tx_data", tx_data, (m_reads - 1) % 65536);
    data_due = 0;
    if (!rst_n) begin
      m_start = 0; m_await = 0; m_err = 0; m_words = 0; m_gap = 0; m_idle = 0;
      m_pkts = 0; m_bytes = 0;
      chk("rst_start", tx_start_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_bytes", tx_byte_num, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_err", err, 0);
      return;
    end
    lvl    = int'(fifo_rd_level);
    idle   = !m_start && (m_words == 0) && !m_await && (m_gap == 0);
    exp_rd = !m_start && (m_words > 0) && tx_req && !fifo_empty;
    chk("tx_start_en", tx_start_en, m_start);
    chk("busy", busy, !idle);
    chk("fifo_rd_en", fifo_rd_en, exp_rd);
    chk("tx_byte_num", tx_byte_num, m_bytes);
    chk("pkt_cnt", pkt_cnt, m_pkts);
    chk("err", err, m_err);
    if (m_start) begin
      m_start = 0;
      m_pkts  = (m_pkts + 1) % 65536;
    end else if (m_words > 0) begin
      if (tx_req && fifo_empty) m_err = 1;
      if (exp_rd) begin
        m_words--;
        if (m_words == 0) m_await = 1;
      end
    end else if (m_await) begin
      if (tx_req) m_err = 1;
      if (tx_done) begin
        m_await = 0;
        m_gap   = GAP_CYC;
      end
    end else if (m_gap > 0) begin
      if (tx_req) m_err = 1;
      m_gap--;
    end else begin
      launch = enable && ((lvl >= PKT_WORDS) || (lvl != 0 && m_idle == TIMEOUT));
      if (launch) begin
        n       = (lvl < PKT_WORDS) ? lvl : PKT_WORDS;
        m_words = n;
        m_bytes = 2 * n;
        m_start = 1;
      end
    end
    if (exp_rd) begin
      m_reads++;
      data_due = 1;
    end
    m_idle = (idle && lvl > 0 && lvl < PKT_WORDS) ? ((m_idle < TIMEOUT) ? m_idle + 1 : TIMEOUT) : 0;
  endtask

  always @(negedge clk) model_cycle();

  task automatic wait_start(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (s_start) begin
        at = s_cyc;
        break;
      end
    end
    if (at < 0) chk("start_wait_expired", 0, 1);
  endtask

  task automatic send(input int nw, input bit rnd, input string name);
    int got;
    got = 0;
    for (int i = 0; i < 4000 && got < nw; i++) begin
      tx_req = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (s_rd) got++;
    end
    tx_req = 1'b0;
    chk(name, got, nw);
  endtask

  task automatic pulse_done(input int push_n, output int at);
    tx_done = 1'b1;
    push(push_n);
    at = cyc;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    int at, p, d, r, c0;
    refresh();
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_pkt_cnt", pkt_cnt, 0);
    chk("reset_bytes", tx_byte_num, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (3) tick();

    // Partial level held constant: forced short packet after the timeout.
    p = cyc;
    push(10);
    wait_start(300, at);
    chk("timeout_latency", at - p, 101);
    chk("timeout_bytes", tx_byte_num, 20);
    send(10, 1'b0, "timeout_reads");
    pulse_done(0, d);
    repeat (20) tick();

    // Full packet from a level above threshold.
    p = cyc;
    push(300);
    wait_start(10, at);
    chk("full_start_latency", at - p, 1);
    chk("full_bytes", tx_byte_num, 512);
    send(256, 1'b0, "full_reads");
    chk("full_pkt_cnt", pkt_cnt, 2);
    chk("full_err", err, 0);

    // Level already full when tx_done arrives: next start waits out the gap.
    pulse_done(256, d);
    wait_start(40, at);
    chk("gap_latency", at - d, 18);
    chk("gap_bytes", tx_byte_num, 512);

    // Random request pattern, then one request too many.
    send(256, 1'b1, "random_reads");
    tx_req = 1'b1;
    tick();
    chk("extra_req_no_read", s_rd, 0);
    tx_req = 1'b0;
    tick();
    chk("extra_req_err", err, 1);

    // Level exactly PKT_WORDS, then reset in the middle of sending.
    pulse_done(212, d);
    wait_start(40, at);
    chk("exact_full_bytes", tx_byte_num, 512);
    send(100, 1'b0, "pre_reset_reads");
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_start", tx_start_en, 0);
    chk("async_rst_rd_en", fifo_rd_en, 0);
    chk("async_rst_bytes", tx_byte_num, 0);
    chk("async_rst_pkt_cnt", pkt_cnt, 0);
    chk("async_rst_err", err, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    r = cyc;
    wait_start(300, at);
    chk("post_rst_latency", at - r, 101);
    chk("post_rst_bytes", tx_byte_num, 312);
    send(156, 1'b0, "post_rst_reads");
    chk("post_rst_pkt_cnt", pkt_cnt, 1);
    pulse_done(0, d);
    repeat (20) tick();

    // Disabled with a full FIFO, then enable dropped mid-packet, with a starved read.
    enable = 1'b0;
    push(500);
    c0 = n_starts;
    repeat (300) tick();
    chk("disabled_no_start", n_starts - c0, 0);
    enable = 1'b1;
    wait_start(5, at);
    chk("enable_bytes", tx_byte_num, 512);
    send(50, 1'b0, "pre_disable_reads");
    enable = 1'b0;
    starve = 1;
    refresh();
    tx_req = 1'b1;
    repeat (3) tick();
    chk("starved_no_read", s_rd, 0);
    tx_req = 1'b0;
    starve = 0;
    refresh();
    chk("starved_err", err, 1);
    send(206, 1'b0, "post_disable_reads");
    pulse_done(0, d);
    c0 = n_starts;
    repeat (300) tick();
    chk("no_restart_disabled", n_starts - c0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_fifo_rd_sched.md
# udp_fifo_rd_sched

Read-side scheduler for the 8→16-bit async audio-capture FIFO feeding the UDP transmitter. It monitors the FIFO read water level and decides when a packet is worth sending: a full packet, or a partial packet after a timeout. It then starts a UDP transmission with the correct byte count and streams exactly that many 16-bit words from the FIFO into the UDP core's data-request handshake. It lives entirely in the FIFO read / UDP TX clock domain.

## Interface
- `DATA_W`, 16: FIFO read data width, equal to the UDP TX data width.
- `LVL_W`, 10: width of `fifo_rd_level`, which is the FIFO read depth width + 1.
- `PKT_WORDS`, 256: words per full packet (1..2^(LVL_W-1)).
- `TIMEOUT`, 50000: idle cycles with a non-zero partial level before a short packet is forced.
- `GAP_CYC`, 16: idle cycles after `tx_done` before the next packet may start.

Ports:
- `clk`, in, 1: single clock, the FIFO rd_clk.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: permits new packets to start.
- `fifo_rd_level`, in, LVL_W: FIFO read water level.
- `fifo_empty`, in, 1: FIFO read empty.
- `fifo_rd_data`, in, DATA_W: FIFO read data, valid 1 cycle after `fifo_rd_en`.
- `fifo_rd_en`, out, 1: FIFO read enable.
- `tx_start_en`, out, 1: one-cycle pulse that starts a UDP packet.
- `tx_byte_num`, out, 16: packet payload length in bytes.
- `tx_req`, in, 1: UDP core requests one word; it expects data on the next cycle.
- `tx_data`, out, DATA_W: payload word to the UDP core.
- `tx_done`, in, 1: one-cycle pulse at the end of the UDP packet.
- `busy`, out, 1: high in every state except IDLE.
- `pkt_cnt`, out, 16: number of packets started; wraps at 2^16.
- `err`, out, 1: sticky error flag; only `rst_n` clears it.

## Operation
- States are IDLE, START, SEND, WAIT_DONE and GAP.
- **IDLE**, leave when `enable` is high and either condition holds:
  - `fifo_rd_level >= PKT_WORDS`, or
  - `fifo_rd_level != 0` and `timer == TIMEOUT`.
  - On leaving, latch `n = min(fifo_rd_level, PKT_WORDS)` into `rem` and set `tx_byte_num = 2*n` (zero-extended to 16 bits). Go to START.
- **Timeout timer**:
  - Counts up in IDLE while `0 < fifo_rd_level < PKT_WORDS`.
  - Saturates at TIMEOUT.
  - Cleared in all other cases, including every non-IDLE state.
  - If `enable` is low, the timer still saturates but no packet starts.
- **START**: `tx_start_en = 1` for exactly this one cycle; `pkt_cnt` increments. Go to SEND.
- **SEND**:
  - `fifo_rd_en = tx_req & (rem != 0) & ~fifo_empty`, a combinational gate from registered state.
  - Each read decrements `rem`.
  - `tx_data = fifo_rd_data`, a straight pass-through.
  - When the last read issues (`rem` goes 1→0), go to WAIT_DONE.
- **WAIT_DONE**: wait for `tx_done`, then go to GAP.
- **GAP**: count GAP_CYC cycles, then go to IDLE.
- **Error cases**, each of which sets `err`:
  - `tx_req` while `rem == 0` (in WAIT_DONE or GAP): no FIFO read occurs and `tx_data` holds its last value.
  - `tx_req & fifo_empty` in SEND: the read is suppressed and `rem` is unchanged.
- `tx_done` outside WAIT_DONE is ignored.
- If `enable` drops mid-packet, the current packet completes normally and no new packet starts.
- The level is conservative on the read side because the write pointer crosses clock domains late. Latching `n` from it therefore guarantees no underflow in normal operation.

## Timing
- Reset values:
  - state IDLE; `fifo_rd_en` 0; `tx_start_en` 0; `tx_byte_num` 0.
  - `rem` 0; `timer` 0; `pkt_cnt` 0; `err` 0; `busy` 0.
  - `tx_data` follows `fifo_rd_data`, so it is not registered.
- Level crossing threshold on cycle t → `tx_start_en` high in cycle t+1 (START), and `busy` high from t+1.
- `tx_req` high in cycle k → `fifo_rd_en` high in cycle k → `tx_data` valid in cycle k+1, which is the UDP core's expected 1-cycle data latency.
- Back-to-back `tx_req` gives one word per cycle with no bubbles.
- After `tx_done` in cycle d, IDLE is re-entered at d+1+GAP_CYC. The earliest next `tx_start_en` is one cycle after that.
- Asserting `rst_n` low mid-packet returns to IDLE immediately and asynchronously, with all outputs at their reset values. The FIFO contents are not touched by this block.

## Structure
- Put state encodings (5 states, one-hot or 3-bit binary) and the UDP byte-count width (16) in a shared UDP package, `udp_pkg`. The same encoding is used by the TX-side blocks.
- No sub-module is needed. Optionally, factor the saturating timer out as `sat_counter` for reuse in the GAP counter.

## Test plan
1. PKT_WORDS=256: pre-fill level to 300, `enable=1` → one `tx_start_en` pulse, `tx_byte_num=512`. Drive 256 consecutive `tx_req` → 256 `fifo_rd_en`, data sequence 0..255 on `tx_data` one cycle later, `err=0`, `pkt_cnt=1`.
2. Level 10 held constant, TIMEOUT=100 → `tx_start_en` exactly 101 cycles after entering IDLE with a non-zero level, `tx_byte_num=20`, 10 reads.
3. `tx_req` toggled randomly 50% during SEND → `fifo_rd_en` mirrors `tx_req` exactly until 256 reads, then stays 0. An extra `tx_req` after the last read → `err=1` and no read.
4. `tx_done` followed by level ≥ 256 at once with GAP_CYC=16 → next `tx_start_en` no earlier than 18 cycles after `tx_done`.
5. Deassert `rst_n` mid-SEND after 100 words → all outputs at reset values the same cycle. After release with level 156 and a timeout → a new packet with `tx_byte_num=312`.
6. `enable=0` with level 500 → no start. Toggle `enable` low during SEND → the packet completes and no second packet starts.
